// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared defaults, widths and one-hot helper for the request front end
package arb_pkg;

  localparam int ARB_N        = 8;
  localparam int ARB_WAIT_MAX = 15;
  localparam int ARB_WAIT_W   = $clog2(ARB_WAIT_MAX + 1);

  function automatic int wait_width(input int wait_max);
    return $clog2(wait_max + 1);
  endfunction

  // Callers slice the result down to their own requester count.
  function automatic logic [63:0] onehot(input int idx);
    return 64'(1) << idx;
  endfunction

endpackage

// File: rtl/arb_wait_ctr.sv
// rtl/arb_wait_ctr.sv - per-requester saturating wait counter with starvation flag
module arb_wait_ctr #(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pending,
  input  logic              ack,
  output logic [WAIT_W-1:0] cnt,
  output logic              sat
);

  localparam logic [WAIT_W-1:0] CNT_MAX = WAIT_W'(WAIT_MAX);

  logic [WAIT_W-1:0] cnt_n;

  always_comb begin
    cnt_n = '0;
    if (!ack && pending) begin
      cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_n;
    end
  end

  assign sat = (cnt == CNT_MAX);

endmodule

// File: rtl/arb_req_front.sv
// rtl/arb_req_front.sv - request capture, priority token and grant bookkeeping for a downstream arbiter
module arb_req_front
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int WAIT_MAX = ARB_WAIT_MAX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_pulse,
  input  logic         rr_en,
  input  logic [N-1:0] ack_i,
  output logic [N-1:0] req_i,
  output logic [N-1:0] prio,
  output logic [N-1:0] done_o,
  output logic         busy,
  output logic [7:0]   grant_cnt,
  output logic         err
);

  localparam int           WAIT_W = wait_width(WAIT_MAX);
  localparam logic [N-1:0] ONE    = N'(1);

  logic [N-1:0] pending;
  logic [N-1:0] pending_n;
  logic [N-1:0] sat_vec;
  logic [N-1:0] starve;
  logic [N-1:0] prio_n;
  logic [N-1:0] live_ack;
  logic         multi_ack;
  logic         stray_ack;
  logic [63:0]  oh_wide;
  int           starve_idx;
  int           ack_idx;
  logic         starve_hit;
  logic         ack_hit;

  for (genvar k = 0; k < N; k++) begin : g_ctr
    logic [WAIT_W-1:0] cnt;
    arb_wait_ctr #(
      .WAIT_MAX(WAIT_MAX),
      .WAIT_W  (WAIT_W)
    ) u_ctr (
      .clk    (clk),
      .rst    (rst),
      .pending(pending[k]),
      .ack    (ack_i[k]),
      .cnt    (cnt),
      .sat    (sat_vec[k])
    );
  end

  // A same-cycle re-request wins over the ack so the client is not lost.
  assign pending_n = (pending & ~ack_i) | req_pulse;
  assign starve    = pending & sat_vec;
  assign live_ack  = ack_i & pending;
  assign multi_ack = |(ack_i & (ack_i - ONE));
  assign stray_ack = |(ack_i & ~pending);

  always_comb begin
    starve_hit = 1'b0;
    ack_hit    = 1'b0;
    starve_idx = 0;
    ack_idx    = 0;
    oh_wide    = '0;
    prio_n     = prio;
    // Descending scan leaves the lowest set index behind.
    for (int k = N - 1; k >= 0; k--) begin
      if (starve[k]) begin
        starve_hit = 1'b1;
        starve_idx = k;
      end
      if (ack_i[k]) begin
        ack_hit = 1'b1;
        ack_idx = k;
      end
    end
    if (starve_hit) begin
      oh_wide = onehot(starve_idx);
      prio_n  = oh_wide[N-1:0];
    end else if (rr_en && ack_hit) begin
      oh_wide = onehot((ack_idx == N - 1) ? 0 : ack_idx + 1);
      prio_n  = oh_wide[N-1:0];
    end else if (!rr_en) begin
      prio_n = ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      prio      <= ONE;
      done_o    <= '0;
      grant_cnt <= '0;
      err       <= 1'b0;
    end else begin
      pending   <= pending_n;
      prio      <= prio_n;
      done_o    <= live_ack;
      grant_cnt <= (|live_ack) ? grant_cnt + 8'd1 : grant_cnt;
      err       <= err | multi_ack | stray_ack;
    end
  end

  assign req_i = pending;
  assign busy  = |pending;

endmodule

// File: tb/tb_arb_req_front.sv
// tb/tb_arb_req_front.sv - directed self-checking bench for arb_req_front (N=8, WAIT_MAX=15)
module tb_arb_req_front;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_pulse;
  logic       rr_en;
  logic [7:0] ack_i;
  logic [7:0] req_i;
  logic [7:0] prio;
  logic [7:0] done_o;
  logic       busy;
  logic [7:0] grant_cnt;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  arb_req_front #(.N(8), .WAIT_MAX(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_pulse(req_pulse),
    .rr_en    (rr_en),
    .ack_i    (ack_i),
    .req_i    (req_i),
    .prio     (prio),
    .done_o   (done_o),
    .busy     (busy),
    .grant_cnt(grant_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_i"}, 32'(req_i), 32'h00);
    check({tag, "_prio"}, 32'(prio), 32'h01);
    check({tag, "_done"}, 32'(done_o), 32'h00);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_gcnt"}, 32'(grant_cnt), 32'h00);
    check({tag, "_err"}, 32'(err), 32'h0);
  endtask

  initial begin
    rst = 1'b1; req_pulse = 8'h00; rr_en = 1'b1; ack_i = 8'h00;
    tick();
    tick();
    check_reset_state("rst");
    rst = 1'b0;

    // round robin: pulse 81, ack 01 two cycles later
    req_pulse = 8'h81;
    tick();
    req_pulse = 8'h00;
    check("rr_req_t1", 32'(req_i), 32'h81);
    check("rr_busy_t1", 32'(busy), 32'h1);
    check("rr_prio_t1", 32'(prio), 32'h01);
    tick();
    ack_i = 8'h01;
    tick();
    check("rr_req_t3", 32'(req_i), 32'h80);
    check("rr_prio_t3", 32'(prio), 32'h02);
    check("rr_done_t3", 32'(done_o), 32'h01);
    check("rr_gcnt_t3", 32'(grant_cnt), 32'd1);

    // wrap from requester 7 back to 0
    ack_i = 8'h80;
    tick();
    ack_i = 8'h00;
    check("wrap_prio", 32'(prio), 32'h01);
    check("wrap_done", 32'(done_o), 32'h80);
    check("wrap_req", 32'(req_i), 32'h00);
    check("wrap_gcnt", 32'(grant_cnt), 32'd2);
    tick();
    check("wrap_done_once", 32'(done_o), 32'h00);
    check("wrap_busy", 32'(busy), 32'h0);

    // move prio off bit 0, then fixed mode forces it back
    req_pulse = 8'h06;
    tick();
    req_pulse = 8'h00;
    ack_i = 8'h02;
    tick();
    check("rr_prio_04", 32'(prio), 32'h04);
    rr_en = 1'b0;
    ack_i = 8'h04;
    tick();
    ack_i = 8'h00;
    check("fix_prio", 32'(prio), 32'h01);
    check("fix_done", 32'(done_o), 32'h04);
    check("fix_gcnt", 32'(grant_cnt), 32'd4);
    check("fix_err", 32'(err), 32'h0);
    rr_en = 1'b1;

    // starvation of requester 2
    req_pulse = 8'h04;
    tick();
    req_pulse = 8'h00;
    repeat (15) tick();
    check("starve_t16_prio", 32'(prio), 32'h01);
    tick();
    check("starve_t17_prio", 32'(prio), 32'h04);
    tick();
    tick();
    check("starve_hold", 32'(prio), 32'h04);
    ack_i = 8'h04;
    tick();
    ack_i = 8'h00;
    check("starve_ack_prio", 32'(prio), 32'h04);
    check("starve_ack_done", 32'(done_o), 32'h04);
    check("starve_ack_req", 32'(req_i), 32'h00);
    tick();
    check("starve_after_prio", 32'(prio), 32'h04);
    check("starve_gcnt", 32'(grant_cnt), 32'd5);

    // re-request and ack of requester 3 in the same cycle
    req_pulse = 8'h08;
    tick();
    ack_i = 8'h08;
    tick();
    req_pulse = 8'h00;
    ack_i = 8'h00;
    check("sim_req", 32'(req_i), 32'h08);
    check("sim_done", 32'(done_o), 32'h08);
    check("sim_prio", 32'(prio), 32'h10);
    check("sim_gcnt", 32'(grant_cnt), 32'd6);
    tick();
    check("sim_done_once", 32'(done_o), 32'h00);
    check("sim_req_held", 32'(req_i), 32'h08);
    // counter restarted from 0 at the ack, so starvation lands 17 cycles after it
    repeat (14) tick();
    check("sim_ctr_t16", 32'(prio), 32'h10);
    tick();
    check("sim_ctr_t17", 32'(prio), 32'h08);
    ack_i = 8'h08;
    tick();
    ack_i = 8'h00;
    check("sim_clear_gcnt", 32'(grant_cnt), 32'd7);
    check("sim_clear_err", 32'(err), 32'h0);

    // multi-bit ack on two pending requesters
    req_pulse = 8'h03;
    tick();
    req_pulse = 8'h00;
    ack_i = 8'h03;
    tick();
    ack_i = 8'h00;
    check("multi_err", 32'(err), 32'h1);
    check("multi_req", 32'(req_i), 32'h00);
    check("multi_prio", 32'(prio), 32'h02);
    check("multi_done", 32'(done_o), 32'h03);
    check("multi_gcnt", 32'(grant_cnt), 32'd8);
    tick();
    check("multi_err_sticky", 32'(err), 32'h1);

    // reset mid-operation, with stimulus on the reset cycle that must be ignored
    req_pulse = 8'hFF;
    tick();
    check("full_req", 32'(req_i), 32'hFF);
    rst = 1'b1;
    ack_i = 8'hFF;
    tick();
    check_reset_state("mid_rst");
    rst = 1'b0;
    req_pulse = 8'h00;
    ack_i = 8'h00;
    tick();
    check("post_rst_done", 32'(done_o), 32'h00);
    check("post_rst_req", 32'(req_i), 32'h00);

    // ack on a requester that is not pending
    ack_i = 8'h10;
    tick();
    ack_i = 8'h00;
    check("stray_err", 32'(err), 32'h1);
    check("stray_gcnt", 32'(grant_cnt), 32'd0);
    check("stray_done", 32'(done_o), 32'h00);
    tick();
    check("stray_err_sticky", 32'(err), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/arb_req_front.md
ARB_REQ_FRONT -- requirements
Module: arb_req_front

Interface
REQ-001 SHALL have parameter N, default 8, number of requesters.
REQ-002 SHALL have parameter WAIT_MAX, default 15, starvation threshold in cycles (WAIT_W = clog2(WAIT_MAX+1) bits).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_pulse  input  N  one-cycle request strobes from clients.
REQ-006 SHALL have port rr_en  input  1  1 = round-robin priority, 0 = fixed priority at requester 0.
REQ-007 SHALL have port ack_i  input  N  per-requester grant from downstream priority arbiter.
REQ-008 SHALL have port req_i  output  N  registered pending requests to the arbiter.
REQ-009 SHALL have port prio  output  N  registered one-hot priority token to the arbiter.
REQ-010 SHALL have port done_o  output  N  one-cycle service-complete pulse per client.
REQ-011 SHALL have port busy  output  1  OR of all pending bits.
REQ-012 SHALL have port grant_cnt  output  8  count of accepted grants, wraps 255 -> 0.
REQ-013 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-014 SHALL set pending[k] at the next edge after req_pulse[k]=1; req_i equals pending (latency 1 cycle).
REQ-015 SHALL clear pending[k] at the edge where ack_i[k]=1, unless req_pulse[k]=1 the same cycle, in which case pending[k] stays 1.
REQ-016 SHALL drive done_o[k]=1 for exactly the cycle after each cycle with ack_i[k]=1 and pending[k]=1.
REQ-017 SHALL keep per-requester wait counter: 0 when not pending; +1 per cycle pending without ack; saturate at WAIT_MAX; reload 0 on ack.
REQ-018 SHALL compute next prio with precedence: (a) starvation: any pending k with counter==WAIT_MAX -> one-hot of lowest such k; (b) else rr_en=1 and ack_i[g]=1 -> one-hot of (g+1) mod N; (c) else rr_en=0 -> one-hot bit 0; (d) else hold.
REQ-019 SHALL rotate from bit N-1 to bit 0 (wrap-around) in REQ-018(b).
REQ-020 SHALL increment grant_cnt by 1 per cycle where ack_i has any bit set on a pending requester.
REQ-021 SHALL set err when ack_i has more than one bit set, or ack_i[k]=1 with pending[k]=0; err holds until reset.
REQ-022 SHALL, on multi-bit ack_i, clear all acked pending bits and rotate from the lowest acked index.
REQ-023 SHALL guarantee prio is always exactly one-hot.

Reset
REQ-024 SHALL, while rst=1 at an edge, load pending=0, wait counters=0, req_i=0, prio=one-hot bit 0, done_o=0, busy=0, grant_cnt=0, err=0.
REQ-025 SHALL apply reset mid-operation identically, discarding all pending requests without done_o pulses.
REQ-026 SHALL ignore req_pulse and ack_i in any cycle where rst=1.

Structure
REQ-027 SHALL place N default, WAIT_MAX default, WAIT_W derivation and a one-hot-of-index helper in shared package arb_pkg.
REQ-028 SHALL implement the per-requester saturating wait counter as sub-module arb_wait_ctr, instantiated N times via generate.
REQ-029 SHALL contain only registers plus next-state logic; no combinational path from ack_i to any output.

Verification (N=8, WAIT_MAX=15)
REQ-030 SHALL cover reset: rst=1 two cycles -> req_i=8'h00, prio=8'h01, done_o=0, busy=0, grant_cnt=0, err=0.
REQ-031 SHALL cover round-robin: rr_en=1, req_pulse=8'h81 at t, ack_i=8'h01 at t+2 -> req_i=8'h81 at t+1, 8'h80 at t+3; prio=8'h02 and done_o=8'h01 at t+3; grant_cnt=1.
REQ-032 SHALL cover wrap and fixed mode: rr_en=1, ack_i=8'h80 -> prio=8'h01 next cycle; rr_en=0, ack_i=8'h04 -> prio stays 8'h01.
REQ-033 SHALL cover starvation: req_pulse=8'h04 at t, no ack -> counter=15 at t+16, prio=8'h04 at t+17, held until ack_i=8'h04.
REQ-034 SHALL cover simultaneous events: pending[3]=1, req_pulse[3]=1 and ack_i=8'h08 same cycle -> req_i[3] stays 1, done_o=8'h08 next cycle, counter[3]=0.
REQ-035 SHALL cover errors and reset mid-operation: ack_i=8'h03 -> err=1 sticky; ack_i=8'h10 with pending[4]=0 -> err=1; rst=1 with req_i=8'hFF -> all outputs per REQ-024 next cycle.
